// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand/opcode widths, opcode constants, legality check
// and the operand-set fill-state encoding.
package alu_pkg;

    localparam int unsigned NB_DATA = 4;
    localparam int unsigned NB_OP   = 6;

    localparam logic [NB_OP-1:0] OP_ADD = 6'b100000;
    localparam logic [NB_OP-1:0] OP_SUB = 6'b100010;
    localparam logic [NB_OP-1:0] OP_AND = 6'b100100;
    localparam logic [NB_OP-1:0] OP_OR  = 6'b100101;
    localparam logic [NB_OP-1:0] OP_XOR = 6'b100110;
    localparam logic [NB_OP-1:0] OP_NOR = 6'b100111;
    localparam logic [NB_OP-1:0] OP_SRA = 6'b000011;
    localparam logic [NB_OP-1:0] OP_SRL = 6'b000010;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        READY   = 2'd2
    } fill_state_t;

    function automatic logic is_legal_op(input logic [NB_OP-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Raw push-button to single-cycle press pulse: 2-FF synchronizer, stable-count
// debounce, and rising-edge detect on the debounced level.
module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise_c
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             level_d_q;

    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            level_d_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], btn};
            level_d_q <= level_q;
            if (sync_q[1] != level_q) begin
                if (cnt_q == CNT_MAX) begin
                    level_q <= sync_q[1];
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign rise_c = level_q & ~level_d_q;

endmodule

// File: rtl/alu_input_loader.sv
// Loads ALU operands A/B and opcode from the switch bank on debounced button
// presses and tracks whether a complete, legal operand set is held.
module alu_input_loader
    import alu_pkg::*;
#(
    parameter int unsigned NB_DATA         = alu_pkg::NB_DATA,
    parameter int unsigned NB_OP           = alu_pkg::NB_OP,
    parameter int unsigned NB_SW           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic [NB_SW-1:0]   i_sw,
    input  logic               i_btn_a,
    input  logic               i_btn_b,
    input  logic               i_btn_op,
    output logic [NB_DATA-1:0] o_datoA,
    output logic [NB_DATA-1:0] o_datoB,
    output logic [NB_OP-1:0]   o_operation,
    output logic               o_valid,
    output logic               o_new,
    output logic               o_err
);

    logic ld_a_c;
    logic ld_b_c;
    logic ld_op_c;

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_a (
        .clk(clk), .rst_n(i_rst_n), .btn(i_btn_a), .rise_c(ld_a_c)
    );
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_b (
        .clk(clk), .rst_n(i_rst_n), .btn(i_btn_b), .rise_c(ld_b_c)
    );
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_op (
        .clk(clk), .rst_n(i_rst_n), .btn(i_btn_op), .rise_c(ld_op_c)
    );

    // Switch bits above the opcode field never reach any register.
    logic unused_sw_c;
    assign unused_sw_c = ^i_sw[NB_SW-1:NB_OP];

    fill_state_t        state_q;
    fill_state_t        state_d;
    logic [2:0]         flags_q;
    logic [2:0]         flags_d;
    logic [NB_DATA-1:0] a_d;
    logic [NB_DATA-1:0] b_d;
    logic [NB_OP-1:0]   op_d;
    logic               err_d;
    logic               valid_d;
    logic               new_d;
    logic               op_ok_c;
    logic               accept_c;

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state_q     <= EMPTY;
            flags_q     <= '0;
            o_datoA     <= '0;
            o_datoB     <= '0;
            o_operation <= '0;
            o_valid     <= 1'b0;
            o_new       <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            state_q     <= state_d;
            flags_q     <= flags_d;
            o_datoA     <= a_d;
            o_datoB     <= b_d;
            o_operation <= op_d;
            o_valid     <= valid_d;
            o_new       <= new_d;
            o_err       <= err_d;
        end
    end

    // All load pulses in a cycle apply together from the same switch sample.
    always_comb begin
        state_d  = state_q;
        flags_d  = flags_q;
        a_d      = o_datoA;
        b_d      = o_datoB;
        op_d     = o_operation;
        err_d    = o_err;
        op_ok_c  = is_legal_op(i_sw[NB_OP-1:0]);
        accept_c = ld_a_c | ld_b_c | (ld_op_c & op_ok_c);

        if (ld_a_c) begin
            a_d        = i_sw[NB_DATA-1:0];
            flags_d[0] = 1'b1;
        end
        if (ld_b_c) begin
            b_d        = i_sw[NB_DATA-1:0];
            flags_d[1] = 1'b1;
        end
        if (ld_op_c) begin
            if (op_ok_c) begin
                op_d       = i_sw[NB_OP-1:0];
                flags_d[2] = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            EMPTY: begin
                if (accept_c) begin
                    state_d = (&flags_d) ? READY : FILLING;
                end
            end
            FILLING: begin
                if (&flags_d) begin
                    state_d = READY;
                end
            end
            READY:   state_d = READY;
            default: state_d = EMPTY;
        endcase

        valid_d = (state_d == READY);
        new_d   = accept_c && (state_d == READY);
    end

endmodule

// File: tb/tb_alu_input_loader.sv
// Scoreboard bench: directed button presses queue the expected output snapshot and
// edge; a negedge monitor pops and compares on every output change.
module tb_alu_input_loader;
    import alu_pkg::*;

    localparam int unsigned DEB = 4;
    localparam int LAT = DEB + 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] sw;
    logic       btn_a, btn_b, btn_op;
    logic [3:0] dato_a, dato_b;
    logic [5:0] operation;
    logic       valid, nw, err;

    alu_input_loader #(
        .NB_DATA(4), .NB_OP(6), .NB_SW(8), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk), .i_rst_n(rst_n), .i_sw(sw),
        .i_btn_a(btn_a), .i_btn_b(btn_b), .i_btn_op(btn_op),
        .o_datoA(dato_a), .o_datoB(dato_b), .o_operation(operation),
        .o_valid(valid), .o_new(nw), .o_err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [16:0] v;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic        mon_en = 1'b0;
    logic [16:0] prev;
    logic [16:0] cur;

    function automatic logic [3:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                           input logic [5:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SRA:  return 4'($signed(a) >>> b);
            OP_SRL:  return a >> b;
            default: return 4'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic push(input int c, input logic [3:0] a, input logic [3:0] b,
                        input logic [5:0] op, input logic v, input logic n, input logic e);
        exp_t x;
        x.cyc = c;
        x.v   = {a, b, op, v, n, e};
        sb_q.push_back(x);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: each change of the output tuple consumes one scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        cur = {dato_a, dato_b, operation, valid, nw, err};
        if (mon_en && cur !== prev) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected cyc=%0d act=%h", cyc, cur);
            end else begin
                e = sb_q.pop_front();
                if (e.cyc != cyc || e.v !== cur) begin
                    n_fail++;
                    $display("FAIL sb_event cyc=%0d exp_cyc=%0d act=%h exp=%h",
                             cyc, e.cyc, cur, e.v);
                end
            end
        end
        prev = cur;
    end

    int t;
    initial begin
        rst_n = 1'b0; sw = 8'h00; btn_a = 1'b0; btn_b = 1'b0; btn_op = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        check("reset_outputs", 32'({dato_a, dato_b, operation, valid, nw, err}), 32'd0);
        check("reset_state", 32'(dut.state_q), 32'(EMPTY));
        mon_en = 1'b1;

        // Load A = 3
        sw = 8'h03; btn_a = 1'b1; t = cyc;
        push(t + LAT, 4'h3, 4'h0, 6'h00, 1'b0, 1'b0, 1'b0);
        tick(10); btn_a = 1'b0; tick(8);
        check("state_filling_a", 32'(dut.state_q), 32'(FILLING));
        check("valid_low_a", 32'(valid), 32'd0);

        // Load B = 5
        sw = 8'h05; btn_b = 1'b1; t = cyc;
        push(t + LAT, 4'h3, 4'h5, 6'h00, 1'b0, 1'b0, 1'b0);
        tick(10); btn_b = 1'b0; tick(8);

        // Load op ADD: completes the set
        sw = 8'h20; btn_op = 1'b1; t = cyc;
        push(t + LAT,     4'h3, 4'h5, 6'b100000, 1'b1, 1'b1, 1'b0);
        push(t + LAT + 1, 4'h3, 4'h5, 6'b100000, 1'b1, 1'b0, 1'b0);
        tick(10); btn_op = 1'b0; tick(8);
        check("state_ready", 32'(dut.state_q), 32'(READY));
        check("alu_leds", 32'(alu_ref(dato_a, dato_b, operation)), 32'b1000);

        // Glitch: 3 cycles high is one short of the debounce window
        sw = 8'h0F; btn_a = 1'b1;
        tick(3); btn_a = 1'b0; tick(12);
        check("glitch_no_load", 32'(dato_a), 32'h3);

        // Bouncy press on B: 1,0,1,1,1,1,1 then held
        sw = 8'h07; t = cyc;
        push(t + 9,  4'h3, 4'h7, 6'b100000, 1'b1, 1'b1, 1'b0);
        push(t + 10, 4'h3, 4'h7, 6'b100000, 1'b1, 1'b0, 1'b0);
        btn_b = 1'b1; tick(1);
        btn_b = 1'b0; tick(1);
        btn_b = 1'b1; tick(10);
        btn_b = 1'b0; tick(8);

        // Illegal opcode in READY
        sw = 8'h3F; btn_op = 1'b1; t = cyc;
        push(t + LAT, 4'h3, 4'h7, 6'b100000, 1'b1, 1'b0, 1'b1);
        tick(10); btn_op = 1'b0; tick(8);
        check("illegal_keeps_ready", 32'(dut.state_q), 32'(READY));
        check("illegal_valid", 32'(valid), 32'd1);

        // Simultaneous A and B
        sw = 8'h09; btn_a = 1'b1; btn_b = 1'b1; t = cyc;
        push(t + LAT,     4'h9, 4'h9, 6'b100000, 1'b1, 1'b1, 1'b1);
        push(t + LAT + 1, 4'h9, 4'h9, 6'b100000, 1'b1, 1'b0, 1'b1);
        tick(10); btn_a = 1'b0; btn_b = 1'b0; tick(8);

        // Reset mid-debounce discards the pending press
        sw = 8'h05; btn_a = 1'b1; t = cyc;
        push(t + 4, 4'h0, 4'h0, 6'h00, 1'b0, 1'b0, 1'b0);
        tick(3); rst_n = 1'b0;
        tick(2); rst_n = 1'b1; btn_a = 1'b0;
        tick(15);
        check("rst_state_empty", 32'(dut.state_q), 32'(EMPTY));
        check("rst_no_late_load", 32'(dato_a), 32'h0);

        // Button held through reset release yields exactly one load
        sw = 8'h06; btn_b = 1'b1; rst_n = 1'b0; t = cyc;
        push(t + 9, 4'h0, 4'h6, 6'h00, 1'b0, 1'b0, 1'b0);
        tick(2); rst_n = 1'b1;
        tick(15); btn_b = 1'b0; tick(10);
        check("held_state_filling", 32'(dut.state_q), 32'(FILLING));

        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_input_loader.md
Name: alu_input_loader

Overview:
- Operator-side producer for the ALU operand/opcode interface (i_datoA, i_datoB, i_operation). It drives those inputs from the board switch bank and three push-buttons.
- Each button press is synchronized, debounced and edge-detected, then latches the switches into the A, B or opcode register.
- A fill-state FSM reports when a complete, legal operand set is held. The ALU result then drives the LEDs.

Parameters:
- NB_DATA, 4, operand width; drives ALU datoA/datoB.
- NB_OP, 6, opcode width; drives ALU operation.
- NB_SW, 8, switch bank width; must be >= max(NB_DATA, NB_OP).
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a button level change (10 ms at 100 MHz). Minimum value 2.

Ports:
- clk  in  1  system clock; only clock.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_sw  in  NB_SW  raw switch bank; sampled only at load time, no synchronizer.
- i_btn_a  in  1  raw async button: load A.
- i_btn_b  in  1  raw async button: load B.
- i_btn_op  in  1  raw async button: load opcode.
- o_datoA  out  NB_DATA  latched operand A, to ALU.
- o_datoB  out  NB_DATA  latched operand B, to ALU.
- o_operation  out  NB_OP  latched opcode, to ALU.
- o_valid  out  1  high while the FSM is in READY.
- o_new  out  1  one-cycle pulse on the edge after any register update made while the set is or becomes complete.
- o_err  out  1  sticky: an illegal opcode load was attempted.

Behaviour:
- Interface: one clock `clk`; reset `i_rst_n` is synchronous and active-low.
- Reset (i_rst_n low at an edge):
  - o_datoA = 0, o_datoB = 0, o_operation = 0, o_valid = 0, o_new = 0, o_err = 0.
  - FSM goes to EMPTY and all load flags clear.
  - Synchronizers, debounce counters and debounced levels clear to 0.
  - Reset mid-debounce discards the pending press. A button held through reset release produces exactly one load once it is debounced.
- Button path, per button:
  - 2-FF synchronizer, then debounce counter, then registered rising-edge detect.
  - The debounced level flips once the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive edges. Any agreeing sample zeroes the counter.
  - Only rising edges of the debounced level generate a load pulse (exactly 1 cycle). The release edge generates nothing.
- Latency: let N0 be the first edge sampling the raw button high, with the button held stable. The target register updates at edge N0+DEBOUNCE_CYCLES+2.
- Load A / load B: register takes i_sw[NB_DATA-1:0] and sets its loaded flag.
- Load op: i_sw[NB_OP-1:0] is checked against the legal set in the package.
  - Legal: o_operation is updated and its flag set.
  - Illegal: o_operation and its flag are unchanged, and o_err is set. o_err stays set until reset.
- Simultaneous load pulses in one cycle: all apply on the same edge from the same i_sw sample. There is no priority.
- FSM states: EMPTY (no flags), FILLING (1-2 flags), READY (all 3 flags).
  - EMPTY -> FILLING on any accepted load.
  - FILLING -> READY on the edge where the third flag sets; this may come directly from EMPTY on a triple load.
  - READY stays READY on further loads; values update in place.
  - Only reset leaves READY.
- o_valid is registered from the state: high in the same cycle the registers reflect the complete set.
- o_new pulses the cycle after:
  - the FILLING/EMPTY -> READY transition, or
  - any accepted load while in READY.
  - A rejected illegal opcode does not pulse o_new.
- Switch upper bits above NB_DATA / NB_OP are ignored.

Decomposition:
- Shared package `alu_pkg`:
  - localparams NB_DATA and NB_OP defaults.
  - Opcode constants OP_ADD=100000, OP_SUB=100010, OP_AND=100100, OP_OR=100101, OP_XOR=100110, OP_NOR=100111, OP_SRA=000011, OP_SRL=000010.
  - A legal-opcode check function.
  - FSM state encodings EMPTY/FILLING/READY.
  - The ALU uses the same constants.
- One sub-module `btn_conditioner`: synchronizer + debounce + rise pulse, parameter DEBOUNCE_CYCLES. Instantiated 3 times.

Test Plan (DEBOUNCE_CYCLES=4 in bench):
- Reset, then press A with i_sw=0x03 held 10 cycles -> o_datoA=4'b0011 at edge N0+6; o_valid=0; FSM FILLING.
- Load B=0x05, then op with i_sw=0x20 -> o_datoB=4'b0101, o_operation=100000; o_valid rises with the op update; o_new pulses once. Checked against the ALU: o_leds=4'b1000.
- Button glitch high for 3 cycles -> no load, no o_new.
- Bouncy press (1,0,1,1,1,1,1) -> exactly one load.
- In READY, load op i_sw=0x3F (illegal) -> o_err=1; o_operation stays 100000; o_valid stays 1; no o_new.
- Press A and B on the same cycle with i_sw=0x09 -> both become 1001 on the same edge.
- Assert i_rst_n low mid-debounce -> all outputs 0; no late load after release unless the button is still held.
